// File: rtl/prog_loader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : prog_loader
// Purpose  : Framed byte-stream loader for the 4-bit computer's program and
//            data memories; optional trailing checksum via PROG_LOADER_CHECKSUM_EN.
// Revision : 1.0
// ============================================================================
module prog_loader #(
    parameter int         DEPTH    = 16,
    parameter logic [7:0] HDR_BYTE = 8'hA5
) (
    input  logic                     prog_clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     s_valid,
    input  logic [7:0]               s_data,
    output logic                     s_ready,
    output logic                     prog_we,
    output logic [$clog2(DEPTH)-1:0] prog_add,
    output logic [7:0]               prog_in,
    output logic [3:0]               data_nib,
    output logic                     cpu_reset,
    output logic                     busy,
    output logic                     done,
    output logic [1:0]               err_code
);
    localparam int            AW     = $clog2(DEPTH);
    localparam logic [AW-1:0] C_LAST = AW'(DEPTH - 1);

    localparam logic [2:0] C_IDLE = 3'd0;
    localparam logic [2:0] C_HDR  = 3'd1;
    localparam logic [2:0] C_INS  = 3'd2;
    localparam logic [2:0] C_DAT  = 3'd3;
    localparam logic [2:0] C_WR   = 3'd4;
    localparam logic [2:0] C_DONE = 3'd6;
    localparam logic [2:0] C_ERR  = 3'd7;

    localparam logic [1:0] C_ERR_HDR = 2'b01;
`ifdef PROG_LOADER_CHECKSUM_EN
    localparam logic [2:0] C_CHK       = 3'd5;
    localparam logic [1:0] C_ERR_SUM   = 2'b10;
    localparam logic [2:0] C_AFTER_WR  = C_CHK;
`else
    localparam logic [2:0] C_AFTER_WR  = C_DONE;
`endif

    logic [2:0]    r_state;
    logic [AW-1:0] r_addr;
    logic          r_s_ready;
    logic          r_prog_we;
    logic [7:0]    r_prog_in;
    logic [3:0]    r_data_nib;
    logic          r_cpu_reset;
    logic          r_busy;
    logic          r_done;
    logic [1:0]    r_err_code;
`ifdef PROG_LOADER_CHECKSUM_EN
    logic [7:0]    r_acc;
`endif

    logic [2:0] w_next;
    logic       w_xfer;
    logic       w_restart;
    logic       w_ready_next;
    logic       w_busy_next;

    // r_s_ready mirrors the current state, so this has no path from s_valid to s_ready
    assign w_xfer    = s_valid && r_s_ready;
    assign w_restart = start && ((r_state == C_IDLE) || (r_state == C_DONE) || (r_state == C_ERR));

    always_comb begin
        w_next = r_state;
        case (r_state)
            C_IDLE, C_DONE, C_ERR: if (start) w_next = C_HDR;
            C_HDR:  if (w_xfer) w_next = (s_data == HDR_BYTE) ? C_INS : C_ERR;
            C_INS:  if (w_xfer) w_next = C_DAT;
            C_DAT:  if (w_xfer) w_next = C_WR;
            C_WR:   w_next = (r_addr == C_LAST) ? C_AFTER_WR : C_INS;
`ifdef PROG_LOADER_CHECKSUM_EN
            C_CHK:  if (w_xfer) w_next = (s_data == r_acc) ? C_DONE : C_ERR;
`endif
            default: w_next = C_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they align with it
    always_comb begin
        w_ready_next = 1'b0;
        w_busy_next  = 1'b0;
        case (w_next)
            C_HDR, C_INS, C_DAT: begin
                w_ready_next = 1'b1;
                w_busy_next  = 1'b1;
            end
            C_WR: w_busy_next = 1'b1;
`ifdef PROG_LOADER_CHECKSUM_EN
            C_CHK: begin
                w_ready_next = 1'b1;
                w_busy_next  = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge prog_clk) begin
        if (reset) begin
            r_state     <= C_IDLE;
            r_addr      <= '0;
            r_s_ready   <= 1'b0;
            r_prog_we   <= 1'b0;
            r_prog_in   <= 8'h00;
            r_data_nib  <= 4'h0;
            r_cpu_reset <= 1'b1;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err_code  <= 2'b00;
`ifdef PROG_LOADER_CHECKSUM_EN
            r_acc       <= 8'h00;
`endif
        end else begin
            r_state   <= w_next;
            r_s_ready <= w_ready_next;
            r_busy    <= w_busy_next;
            r_prog_we <= (w_next == C_WR);
            r_done    <= (w_next == C_DONE);

            if (w_restart) begin
                r_addr      <= '0;
                r_cpu_reset <= 1'b1;
                r_err_code  <= 2'b00;
`ifdef PROG_LOADER_CHECKSUM_EN
                r_acc       <= 8'h00;
`endif
            end else if (r_state == C_DONE) begin
                r_cpu_reset <= 1'b0;
            end

            if ((r_state == C_INS) && w_xfer)
                r_prog_in <= s_data;
            if ((r_state == C_DAT) && w_xfer)
                r_data_nib <= s_data[3:0];
`ifdef PROG_LOADER_CHECKSUM_EN
            if (((r_state == C_INS) || (r_state == C_DAT)) && w_xfer)
                r_acc <= r_acc + s_data;
            if ((r_state == C_CHK) && w_xfer && (s_data != r_acc))
                r_err_code <= C_ERR_SUM;
`endif
            // Address holds at the last word so prog_add reports it after the load
            if ((r_state == C_WR) && (r_addr != C_LAST))
                r_addr <= r_addr + AW'(1);
            if ((r_state == C_HDR) && w_xfer && (s_data != HDR_BYTE))
                r_err_code <= C_ERR_HDR;
        end
    end

    assign s_ready   = r_s_ready;
    assign prog_we   = r_prog_we;
    assign prog_add  = r_addr;
    assign prog_in   = r_prog_in;
    assign data_nib  = r_data_nib;
    assign cpu_reset = r_cpu_reset;
    assign busy      = r_busy;
    assign done      = r_done;
    assign err_code  = r_err_code;

endmodule
`default_nettype wire

// File: tb/tb_prog_loader.sv
`timescale 1ns/1ps
`default_nettype none
// Testbench for prog_loader: table of load scenarios checked against a stream-level
// reference model, plus a mid-load reset sequence.
module tb_prog_loader;
    logic       prog_clk = 1'b0;
    logic       reset    = 1'b1;
    logic       start    = 1'b0;
    logic       s_valid  = 1'b0;
    logic [7:0] s_data   = 8'h00;
    logic       s_ready;
    logic       prog_we;
    logic [3:0] prog_add;
    logic [7:0] prog_in;
    logic [3:0] data_nib;
    logic       cpu_reset;
    logic       busy;
    logic       done;
    logic [1:0] err_code;

    prog_loader dut (
        .prog_clk  (prog_clk),
        .reset     (reset),
        .start     (start),
        .s_valid   (s_valid),
        .s_data    (s_data),
        .s_ready   (s_ready),
        .prog_we   (prog_we),
        .prog_add  (prog_add),
        .prog_in   (prog_in),
        .data_nib  (data_nib),
        .cpu_reset (cpu_reset),
        .busy      (busy),
        .done      (done),
        .err_code  (err_code)
    );

    always #5 prog_clk = ~prog_clk;

`ifdef PROG_LOADER_CHECKSUM_EN
    localparam int C_DONE_CYC = 50;
`else
    localparam int C_DONE_CYC = 49;
`endif
    localparam int C_MAXC = 3000;

    typedef struct {
        int         kind;     // 0 canonical, 1 bad header, 2 bad checksum, 3 random payload
        int         vprob;    // percent chance s_valid is high each cycle
        bit         exp_done;
        logic [1:0] exp_err;
        int         exp_nwr;
    } vec_t;

    vec_t        vecs[$];
    logic [7:0]  img_q[$];
    logic [15:0] exp_q[$];
    logic [15:0] wq[$];
    int          n_checks = 0;
    int          n_pass   = 0;
    logic        prev_we  = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    always @(negedge prog_clk) begin
        if (prog_we) begin
            check("we_single_cycle", {31'd0, prev_we}, 32'd0);
            wq.push_back({prog_add, prog_in, data_nib});
        end
        prev_we = prog_we;
    end

    task automatic build_image(input int kind);
        logic [7:0] sum = 8'h00;
        logic [7:0] b;
        img_q.delete();
        if (kind == 1) begin
            img_q.push_back(8'h5A);
        end else begin
            img_q.push_back(8'hA5);
            for (int i = 0; i < 32; i++) begin
                if (kind == 3) b = 8'($urandom);
                else if (i % 2 == 0) b = 8'h70 + 8'(i / 2);
                else b = 8'(i / 2);
                img_q.push_back(b);
                sum = sum + b;
            end
`ifdef PROG_LOADER_CHECKSUM_EN
            img_q.push_back((kind == 2) ? sum + 8'h01 : sum);
`endif
        end
    endtask

    // Reference: a valid header yields word i = (addr i, stream byte 1+2i, low nibble of byte 2+2i)
    task automatic model_writes();
        exp_q.delete();
        if (img_q.size() > 32 && img_q[0] == 8'hA5)
            for (int i = 0; i < 16; i++)
                exp_q.push_back({4'(i), img_q[1 + 2 * i], img_q[2 + 2 * i][3:0]});
    endtask

    task automatic do_start();
        @(negedge prog_clk);
        start = 1'b1;
        @(posedge prog_clk);
        #1;
        start = 1'b0;
    endtask

    task automatic drive(input int vprob, input int stop_we,
                         output int done_cyc, output int cpu_cyc, output bit timeout);
        int idx  = 0;
        int cyc  = 0;
        int tail = 0;
        int wes  = 0;
        bit xfer;
        done_cyc = -1;
        cpu_cyc  = -1;
        timeout  = 1'b0;
        forever begin
            @(negedge prog_clk);
            if (idx < img_q.size()) begin
                s_valid = ($urandom_range(99) < vprob);
                s_data  = s_valid ? img_q[idx] : 8'($urandom);
            end else begin
                s_valid = 1'b0;
                s_data  = 8'($urandom);
            end
            start = (vprob < 100 && !done && err_code == 2'b00) ? ($urandom_range(7) == 0) : 1'b0;
            xfer  = s_valid && s_ready;
            @(posedge prog_clk);
            if (xfer) idx++;
            #1;
            start = 1'b0;
            cyc++;
            if (done && done_cyc < 0) done_cyc = cyc;
            if (!cpu_reset && cpu_cyc < 0) cpu_cyc = cyc;
            if (prog_we) wes++;
            if (stop_we != 0 && wes == stop_we) break;
            if (done || err_code != 2'b00) tail++;
            if (tail >= 3) break;
            if (cyc >= C_MAXC) begin
                timeout = 1'b1;
                break;
            end
        end
        s_valid = 1'b0;
    endtask

    initial begin
        int dc, cc;
        bit to;
        vecs.push_back('{0, 100, 1'b1, 2'b00, 16});
        vecs.push_back('{1, 100, 1'b0, 2'b01, 0});
`ifdef PROG_LOADER_CHECKSUM_EN
        vecs.push_back('{2, 100, 1'b0, 2'b10, 16});
`endif
        vecs.push_back('{3, 100, 1'b1, 2'b00, 16});
        vecs.push_back('{0, 40,  1'b1, 2'b00, 16});
        vecs.push_back('{3, 55,  1'b1, 2'b00, 16});
        vecs.push_back('{1, 30,  1'b0, 2'b01, 0});
        vecs.push_back('{0, 100, 1'b1, 2'b00, 16});

        repeat (3) @(posedge prog_clk);
        #1;
        reset = 1'b0;
        check("rst_s_ready",   {31'd0, s_ready},   32'd0);
        check("rst_prog_we",   {31'd0, prog_we},   32'd0);
        check("rst_prog_add",  {28'd0, prog_add},  32'd0);
        check("rst_prog_in",   {24'd0, prog_in},   32'd0);
        check("rst_data_nib",  {28'd0, data_nib},  32'd0);
        check("rst_cpu_reset", {31'd0, cpu_reset}, 32'd1);
        check("rst_busy",      {31'd0, busy},      32'd0);
        check("rst_done",      {31'd0, done},      32'd0);
        check("rst_err_code",  {30'd0, err_code},  32'd0);

        foreach (vecs[v]) begin
            build_image(vecs[v].kind);
            model_writes();
            wq.delete();
            do_start();
            check($sformatf("v%0d_start_s_ready", v),   {31'd0, s_ready},   32'd1);
            check($sformatf("v%0d_start_busy", v),      {31'd0, busy},      32'd1);
            check($sformatf("v%0d_start_done", v),      {31'd0, done},      32'd0);
            check($sformatf("v%0d_start_cpu_reset", v), {31'd0, cpu_reset}, 32'd1);
            check($sformatf("v%0d_start_err", v),       {30'd0, err_code},  32'd0);
            drive(vecs[v].vprob, 0, dc, cc, to);
            check($sformatf("v%0d_timeout", v), {31'd0, to}, 32'd0);
            check($sformatf("v%0d_done", v),      {31'd0, done},      {31'd0, vecs[v].exp_done});
            check($sformatf("v%0d_err_code", v),  {30'd0, err_code},  {30'd0, vecs[v].exp_err});
            check($sformatf("v%0d_cpu_reset", v), {31'd0, cpu_reset}, {31'd0, !vecs[v].exp_done});
            check($sformatf("v%0d_busy", v),      {31'd0, busy},      32'd0);
            check($sformatf("v%0d_s_ready", v),   {31'd0, s_ready},   32'd0);
            check($sformatf("v%0d_prog_add", v),  {28'd0, prog_add},
                  (vecs[v].exp_nwr == 16) ? 32'd15 : 32'd0);
            check($sformatf("v%0d_nwrites", v), wq.size(), vecs[v].exp_nwr);
            for (int i = 0; i < wq.size() && i < exp_q.size(); i++)
                check($sformatf("v%0d_write%0d", v, i), {16'd0, wq[i]}, {16'd0, exp_q[i]});
            if (vecs[v].exp_done && vecs[v].vprob == 100) begin
                check($sformatf("v%0d_done_cycle", v), dc, C_DONE_CYC);
                check($sformatf("v%0d_cpu_rel_cycle", v), cc, C_DONE_CYC + 1);
            end else if (vecs[v].exp_done) begin
                check($sformatf("v%0d_cpu_rel_after_done", v), cc, dc + 1);
            end
        end

        // Reset asserted in the cycle of the 5th write
        build_image(0);
        model_writes();
        wq.delete();
        do_start();
        drive(100, 5, dc, cc, to);
        check("mid_timeout", {31'd0, to}, 32'd0);
        @(negedge prog_clk);
        reset = 1'b1;
        @(posedge prog_clk);
        #1;
        reset = 1'b0;
        check("mid_cpu_reset", {31'd0, cpu_reset}, 32'd1);
        check("mid_busy",      {31'd0, busy},      32'd0);
        check("mid_s_ready",   {31'd0, s_ready},   32'd0);
        check("mid_prog_we",   {31'd0, prog_we},   32'd0);
        check("mid_prog_add",  {28'd0, prog_add},  32'd0);
        check("mid_prog_in",   {24'd0, prog_in},   32'd0);
        check("mid_data_nib",  {28'd0, data_nib},  32'd0);
        check("mid_done",      {31'd0, done},      32'd0);
        check("mid_err_code",  {30'd0, err_code},  32'd0);
        check("mid_nwrites",   wq.size(), 5);

        wq.delete();
        do_start();
        drive(100, 0, dc, cc, to);
        check("post_timeout",   {31'd0, to},        32'd0);
        check("post_done",      {31'd0, done},      32'd1);
        check("post_cpu_reset", {31'd0, cpu_reset}, 32'd0);
        check("post_done_cycle", dc, C_DONE_CYC);
        check("post_nwrites",   wq.size(), 16);
        for (int i = 0; i < wq.size() && i < exp_q.size(); i++)
            check($sformatf("post_write%0d", i), {16'd0, wq[i]}, {16'd0, exp_q[i]});

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
